// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: sends {we,5'b0,addr} then wdata/0x00 under one SS frame, returns read byte.
// Optional build macro SPI_MASTER_MISO_SYNC_EN adds a 2-flop MISO synchroniser.
module spi_master_ctrl #(
   parameter int SCLK_HALF = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       we,
   input  logic [1:0] addr,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       busy,
   output logic       done,
   output logic       SCLK,
   output logic       MOSI,
   input  logic       MISO,
   output logic       SS
);

   localparam int CW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(SCLK_HALF - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEAD,
      S_HIGH,
      S_LOW,
      S_TRAIL
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [3:0]    r_bit;
   logic [15:0]   r_tx;
   logic [7:0]    r_rx;
   logic          r_we;
   logic          r_sclk;
   logic          r_mosi;
   logic          r_ss;
   logic          r_busy;
   logic          r_done;
   logic [7:0]    r_rdata;
   logic          w_miso;
   logic          w_phase_end;
   logic          w_accept;
   logic          w_capture;
   logic          w_shift;

`ifdef SPI_MASTER_MISO_SYNC_EN
   localparam logic [CW-1:0] CAP_CNT = CW'(2);
   logic r_miso_s1;
   logic r_miso_s2;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_miso_s1 <= 1'b0;
         r_miso_s2 <= 1'b0;
      end else begin
         r_miso_s1 <= MISO;
         r_miso_s2 <= r_miso_s1;
      end
   end

   assign w_miso = r_miso_s2;
`else
   localparam logic [CW-1:0] CAP_CNT = '0;
   assign w_miso = MISO;
`endif

   // Outputs lag the state by one register stage, so a new request is also
   // blocked while the previous frame's busy/done are still visible.
   assign w_phase_end = (r_cnt == LAST_CNT);
   assign w_accept    = (r_state == S_IDLE) && start && !r_busy && !r_done;
   assign w_capture   = (r_state == S_HIGH) && (r_cnt == CAP_CNT);
   assign w_shift     = (r_state == S_HIGH) && w_phase_end && (r_bit != 4'd15);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   // NOTE: default assigned first so every path drives w_state_nxt (no latch).
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept)    w_state_nxt = S_LEAD;
         S_LEAD:  if (w_phase_end) w_state_nxt = S_HIGH;
         S_HIGH:  if (w_phase_end) w_state_nxt = (r_bit == 4'd15) ? S_TRAIL : S_LOW;
         S_LOW:   if (w_phase_end) w_state_nxt = S_HIGH;
         S_TRAIL: if (w_phase_end) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt   <= '0;
         r_bit   <= 4'd0;
         r_tx    <= 16'h0000;
         r_rx    <= 8'h00;
         r_we    <= 1'b0;
         r_sclk  <= 1'b0;
         r_mosi  <= 1'b0;
         r_ss    <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_rdata <= 8'h00;
      end else begin
         r_cnt <= ((r_state == S_IDLE) || w_phase_end) ? '0 : r_cnt + CW'(1);

         if (w_accept) begin
            r_tx  <= {we, 5'b00000, addr, (we ? wdata : 8'h00)};
            r_we  <= we;
            r_bit <= 4'd0;
         end else if (w_shift) begin
            r_tx  <= {r_tx[14:0], 1'b0};
            r_bit <= r_bit + 4'd1;
         end

         if (w_capture) r_rx <= {r_rx[6:0], w_miso};

         r_ss   <= (r_state == S_IDLE);
         r_busy <= (r_state != S_IDLE);
         r_sclk <= (r_state == S_HIGH);
         r_mosi <= (r_state != S_IDLE) && r_tx[15];
         // First IDLE cycle while busy is still high marks the end of a frame.
         r_done <= (r_state == S_IDLE) && r_busy;
         if ((r_state == S_IDLE) && r_busy && !r_we) r_rdata <= r_rx;
      end
   end

   assign rdata = r_rdata;
   assign busy  = r_busy;
   assign done  = r_done;
   assign SCLK  = r_sclk;
   assign MOSI  = r_mosi;
   assign SS    = r_ss;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: instance A at H=4, instance B at the minimum divider,
// shared SPI slave model/monitor and an expected-result queue.
module tb_spi_master_ctrl;

   localparam int H_A = 4;
`ifdef SPI_MASTER_MISO_SYNC_EN
   localparam int H_B = 3;
   localparam logic [7:0] SB_B = 8'h96;
`else
   localparam int H_B = 2;
   localparam logic [7:0] SB_B = 8'hFF;
`endif

   typedef struct packed {
      logic [15:0] mosi;
      logic [7:0]  rdata;
   } exp_t;

   exp_t exp_q[$];
   logic [7:0] rd_model [2];

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_a = 1'b0;
   logic       start_b = 1'b0;
   logic       we = 1'b0;
   logic [1:0] addr = 2'd0;
   logic [7:0] wdata = 8'h00;
   logic       miso = 1'b0;
   logic       sel = 1'b0;

   logic [7:0] rdata_a, rdata_b;
   logic       busy_a, busy_b, done_a, done_b;
   logic       sclk_a, sclk_b, mosi_a, mosi_b, ss_a, ss_b;

   logic [7:0] rdata;
   logic       busy, done, sclk, mosi, ss;
   int         h_cur;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   spi_master_ctrl #(.SCLK_HALF(H_A)) u_dut_a (
      .clk(clk), .rst(rst), .start(start_a), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata_a), .busy(busy_a), .done(done_a), .SCLK(sclk_a), .MOSI(mosi_a),
      .MISO(miso), .SS(ss_a)
   );

   spi_master_ctrl #(.SCLK_HALF(H_B)) u_dut_b (
      .clk(clk), .rst(rst), .start(start_b), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata_b), .busy(busy_b), .done(done_b), .SCLK(sclk_b), .MOSI(mosi_b),
      .MISO(miso), .SS(ss_b)
   );

   assign rdata = sel ? rdata_b : rdata_a;
   assign busy  = sel ? busy_b  : busy_a;
   assign done  = sel ? done_b  : done_a;
   assign sclk  = sel ? sclk_b  : sclk_a;
   assign mosi  = sel ? mosi_b  : mosi_a;
   assign ss    = sel ? ss_b    : ss_a;
   assign h_cur = sel ? H_B : H_A;

   // Cycle index: value equals the number of rising edges seen so far.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Slave model and timing monitor, evaluated on the falling clk edge.
   logic        sclk_p = 1'b0, ss_p = 1'b1, mosi_p = 1'b0;
   logic [15:0] rx_word = '0, slv_sh = '0, slv_word = '0;
   logic [7:0]  rdata_at_done = '0;
   int t_ss_fall = 0, t_ss_rise = 0, t_done = 0, last_rise = 0, last_fall = 0;
   int rises = 0, phase_err = 0, mosi_err = 0, busy_err = 0, edge_err = 0, done_cnt = 0;
   int rise_t [16];

   always @(negedge clk) begin
      if (ss_p && !ss) begin
         t_ss_fall = cyc;
         rises     = 0;
         rx_word   = '0;
         slv_sh    = slv_word;
         miso      = slv_word[15];
         if (sclk) edge_err++;
      end else if (!ss_p && ss) begin
         t_ss_rise = cyc;
         if (sclk) edge_err++;
      end
      if (!ss && !ss_p) begin
         if (sclk && !sclk_p) begin
            if (rises < 16) rise_t[rises] = cyc;
            if (rises > 0 && (cyc - last_fall) != h_cur) phase_err++;
            rx_word   = {rx_word[14:0], mosi};
            rises++;
            last_rise = cyc;
         end else if (!sclk && sclk_p) begin
            if ((cyc - last_rise) != h_cur) phase_err++;
            last_fall = cyc;
            slv_sh    = {slv_sh[14:0], 1'b0};
            miso      = slv_sh[15];
         end
         if (mosi !== mosi_p && sclk) mosi_err++;
      end
      if (busy !== !ss) busy_err++;
      if (done) begin
         done_cnt++;
         t_done        = cyc;
         rdata_at_done = rdata;
      end
      sclk_p = sclk;
      ss_p   = ss;
      mosi_p = mosi;
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) step();
   endtask

   task automatic launch(input logic s, input logic w, input logic [1:0] a,
                         input logic [7:0] d, input logic [7:0] sb, output int c_acc);
      exp_t e;
      step();
      sel      = s;
      slv_word = {8'hC3, sb};
      if (!w) rd_model[s] = sb;
      e.mosi   = {w, 5'b00000, a, (w ? d : 8'h00)};
      e.rdata  = rd_model[s];
      exp_q.push_back(e);
      we = w; addr = a; wdata = d;
      if (s) start_b = 1'b1;
      else   start_a = 1'b1;
      c_acc = cyc + 1;
      step();
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   task automatic wait_done(input int base, output bit ok);
      int n = 0;
      while (done_cnt == base && n < 40 * h_cur + 50) begin
         step();
         n++;
      end
      ok = (done_cnt != base);
   endtask

   task automatic test_reset();
      n_total++;
      if ({ss_a, sclk_a, mosi_a, busy_a, done_a, rdata_a} !== 13'b1_0000_0000_0000) begin
         $display("FAIL reset_a got ss/sclk/mosi/busy/done/rdata=%b want 1_0000_00000000",
                  {ss_a, sclk_a, mosi_a, busy_a, done_a, rdata_a});
      end else n_pass++;
      n_total++;
      if ({ss_b, sclk_b, mosi_b, busy_b, done_b, rdata_b} !== 13'b1_0000_0000_0000) begin
         $display("FAIL reset_b got ss/sclk/mosi/busy/done/rdata=%b want 1_0000_00000000",
                  {ss_b, sclk_b, mosi_b, busy_b, done_b, rdata_b});
      end else n_pass++;
   endtask

   task automatic test_write();
      int c_acc, d0, p0, m0, b0, e0, rerr;
      bit ok;
      exp_t e;
      d0 = done_cnt; p0 = phase_err; m0 = mosi_err; b0 = busy_err; e0 = edge_err;
      launch(1'b0, 1'b1, 2'd2, 8'hA5, 8'h5E, c_acc);
      wait_done(d0, ok);
      n_total++;
      if (!ok) $display("FAIL write_timeout no done within budget");
      else n_pass++;
      wait_cycles(3);
      e = exp_q.pop_front();
      n_total++;
      if (rx_word !== e.mosi) $display("FAIL write_mosi got %h want %h", rx_word, e.mosi);
      else n_pass++;
      n_total++;
      if (rdata_at_done !== e.rdata) $display("FAIL write_rdata got %h want %h", rdata_at_done, e.rdata);
      else n_pass++;
      n_total++;
      if (rises !== 16) $display("FAIL write_rises got %0d want 16", rises);
      else n_pass++;
      n_total++;
      if (done_cnt - d0 !== 1) $display("FAIL write_done_pulses got %0d want 1", done_cnt - d0);
      else n_pass++;
      n_total++;
      if (t_done - c_acc !== 33 * H_A + 1)
         $display("FAIL write_latency got %0d want %0d", t_done - c_acc, 33 * H_A + 1);
      else n_pass++;
      n_total++;
      if (t_ss_fall - c_acc !== 1) $display("FAIL write_ss_fall got %0d want 1", t_ss_fall - c_acc);
      else n_pass++;
      n_total++;
      if (t_ss_rise !== t_done) $display("FAIL write_ss_rise got %0d want %0d", t_ss_rise, t_done);
      else n_pass++;
      rerr = 0;
      for (int k = 0; k < 16; k++)
         if (rise_t[k] - t_ss_fall != (2 * k + 1) * H_A) rerr++;
      n_total++;
      if (rerr !== 0) $display("FAIL write_rise_times got %0d misplaced want 0", rerr);
      else n_pass++;
      n_total++;
      if ({phase_err - p0, mosi_err - m0, busy_err - b0, edge_err - e0} !== 128'd0)
         $display("FAIL write_protocol got phase=%0d mosi=%0d busy=%0d edge=%0d want 0",
                  phase_err - p0, mosi_err - m0, busy_err - b0, edge_err - e0);
      else n_pass++;
   endtask

   task automatic test_read();
      int c_acc, d0, m0;
      bit ok;
      exp_t e;
      d0 = done_cnt; m0 = mosi_err;
      launch(1'b0, 1'b0, 2'd1, 8'h77, 8'h3C, c_acc);
      wait_done(d0, ok);
      n_total++;
      if (!ok) $display("FAIL read_timeout no done within budget");
      else n_pass++;
      wait_cycles(2);
      e = exp_q.pop_front();
      n_total++;
      if (rx_word !== e.mosi) $display("FAIL read_mosi got %h want %h", rx_word, e.mosi);
      else n_pass++;
      n_total++;
      if (rdata_at_done !== e.rdata) $display("FAIL read_rdata got %h want %h", rdata_at_done, e.rdata);
      else n_pass++;
      n_total++;
      if (mosi_err - m0 !== 0) $display("FAIL read_mosi_stable got %0d changes want 0", mosi_err - m0);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int c_acc, d0, d;
      bit ok;
      exp_t e;
      d0 = done_cnt;
      launch(1'b0, 1'b1, 2'd3, 8'h5A, 8'h00, c_acc);
      wait_cycles(10);
      we = 1'b0; addr = 2'd0; wdata = 8'hFF; start_a = 1'b1;
      step();
      start_a = 1'b0;
      wait_done(d0, ok);
      n_total++;
      if (!ok) $display("FAIL b2b_timeout first frame no done");
      else n_pass++;
      d = cyc;
      e = exp_q.pop_front();
      n_total++;
      if (rx_word !== e.mosi) $display("FAIL b2b_latched got %h want %h", rx_word, e.mosi);
      else n_pass++;
      n_total++;
      if (rdata !== e.rdata) $display("FAIL b2b_rdata got %h want %h", rdata, e.rdata);
      else n_pass++;
      we = 1'b1; addr = 2'd1; wdata = 8'h3C; start_a = 1'b1;
      e.mosi  = 16'h813C;
      e.rdata = rd_model[0];
      exp_q.push_back(e);
      step();
      n_total++;
      if ({busy, ss} !== 2'b01) $display("FAIL b2b_after_done got busy,ss=%b want 01", {busy, ss});
      else n_pass++;
      step();
      start_a = 1'b0;
      wait_done(d0 + 1, ok);
      n_total++;
      if (!ok) $display("FAIL b2b_timeout second frame no done");
      else n_pass++;
      n_total++;
      if (t_ss_fall !== d + 3) $display("FAIL b2b_accept_time got %0d want %0d", t_ss_fall, d + 3);
      else n_pass++;
      wait_cycles(2);
      e = exp_q.pop_front();
      n_total++;
      if (rx_word !== e.mosi) $display("FAIL b2b_second_mosi got %h want %h", rx_word, e.mosi);
      else n_pass++;
   endtask

   task automatic test_mid_reset();
      int c_acc, d0, n;
      bit ok;
      exp_t e;
      d0 = done_cnt;
      step();
      sel = 1'b0;
      we = 1'b1; addr = 2'd0; wdata = 8'h11; start_a = 1'b1;
      step();
      start_a = 1'b0;
      step();
      n = 0;
      while (rises < 7 && n < 200) begin
         step();
         n++;
      end
      n_total++;
      if (rises !== 7) $display("FAIL mrst_reach_rise7 got %0d rises want 7", rises);
      else n_pass++;
      rst = 1'b0;
      #1;
      n_total++;
      if ({ss, sclk, mosi, busy, done, rdata} !== 13'b1_0000_0000_0000)
         $display("FAIL mrst_outputs got ss/sclk/mosi/busy/done/rdata=%b want 1_0000_00000000",
                  {ss, sclk, mosi, busy, done, rdata});
      else n_pass++;
      rd_model[0] = 8'h00;
      rd_model[1] = 8'h00;
      wait_cycles(2);
      rst = 1'b1;
      wait_cycles(150);
      n_total++;
      if ({done_cnt - d0, 31'd0, ss} !== 64'd1)
         $display("FAIL mrst_no_done got dones=%0d ss=%b want 0 and 1", done_cnt - d0, ss);
      else n_pass++;
      d0 = done_cnt;
      launch(1'b0, 1'b1, 2'd3, 8'hC7, 8'h00, c_acc);
      wait_done(d0, ok);
      n_total++;
      if (!ok) $display("FAIL mrst_timeout fresh write no done");
      else n_pass++;
      wait_cycles(2);
      e = exp_q.pop_front();
      n_total++;
      if ({rx_word, rdata_at_done} !== {e.mosi, e.rdata})
         $display("FAIL mrst_fresh got %h/%h want %h/%h", rx_word, rdata_at_done, e.mosi, e.rdata);
      else n_pass++;
   endtask

   task automatic test_min_divider();
      int c_acc, d0, p0;
      bit ok;
      exp_t e;
      d0 = done_cnt; p0 = phase_err;
      launch(1'b1, 1'b0, 2'd3, 8'h00, SB_B, c_acc);
      wait_done(d0, ok);
      n_total++;
      if (!ok) $display("FAIL mindiv_timeout no done");
      else n_pass++;
      wait_cycles(2);
      e = exp_q.pop_front();
      n_total++;
      if (rdata_at_done !== e.rdata) $display("FAIL mindiv_rdata got %h want %h", rdata_at_done, e.rdata);
      else n_pass++;
      n_total++;
      if (rx_word !== e.mosi) $display("FAIL mindiv_mosi got %h want %h", rx_word, e.mosi);
      else n_pass++;
      n_total++;
      if (t_done - c_acc !== 33 * H_B + 1)
         $display("FAIL mindiv_latency got %0d want %0d", t_done - c_acc, 33 * H_B + 1);
      else n_pass++;
      n_total++;
      if ({phase_err - p0, rises} !== {32'd0, 32'd16})
         $display("FAIL mindiv_phases got phase_err=%0d rises=%0d want 0 and 16", phase_err - p0, rises);
      else n_pass++;
      step();
      sel = 1'b0;
   endtask

   initial begin
      rd_model[0] = 8'h00;
      rd_model[1] = 8'h00;
      #1 rst = 1'b0;
      wait_cycles(3);
      test_reset();
      rst = 1'b1;
      wait_cycles(2);
      test_write();
      test_read();
      test_back_to_back();
      test_mid_reset();
      test_min_divider();
      wait_cycles(5);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/spi_master_ctrl.md
# spi_master_ctrl

SPI mode-0 master that turns a single host register request into a framed two-byte SPI transaction for the SPI slave register-file block.
- Sits between the AXI-Lite-side host logic and the SPI pins: drives SCLK/MOSI/SS and captures MISO.
- Serialises `{command, data}` MSB-first with SS held low across both bytes.
- Returns read data with a one-cycle `done` pulse.

## Interface
- SCLK_HALF, default 4: clk cycles per SCLK half-period; legal ≥2, or ≥3 with the sync option compiled in.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request strobe; accepted only in IDLE.
- we  input  1  1 = write, 0 = read; sampled with start.
- addr  input  2  slave register index; sampled with start.
- wdata  input  8  write byte; sampled with start.
- rdata  output  8  last read result; valid from done onward.
- busy  output  1  high from SS fall through SS rise.
- done  output  1  one-cycle pulse at transaction end.
- SCLK  output  1  SPI clock, idle low.
- MOSI  output  1  master-out data.
- MISO  input  1  slave-out data; may be Z while SS high (ignored).
- SS  output  1  active-low slave select, idle high.

## Operation
- **Frame (16 bits, MSB first):**
  - Byte0 = `{we, 5'b00000, addr}`.
  - Byte1 = wdata for writes, 0x00 for reads.
- **Capture:** MISO is captured during all 16 bits. rdata is loaded from the byte1 capture on reads only; writes leave rdata unchanged.
- **FSM:** IDLE → LEAD → LOW ↔ HIGH (16 bit-cycles) → TRAIL → IDLE.
  - IDLE: SS=1, SCLK=0. `start=1` latches we/addr/wdata into a 16-bit shift register and moves to LEAD.
  - LEAD: SS=0, MOSI = bit15. Lasts SCLK_HALF cycles, then HIGH.
  - HIGH: SCLK=1. MISO is sampled into the rx shift register in the first cycle of HIGH. Lasts SCLK_HALF cycles.
  - LOW: SCLK=0. The tx register shifts on entry and MOSI presents the next bit. Lasts SCLK_HALF cycles.
  - Bit counter runs 0..15. After the 16th HIGH the FSM goes to TRAIL instead of LOW; there is no 17th MOSI shift, and MOSI holds bit0.
  - TRAIL: SCLK=0 for SCLK_HALF cycles, then SS=1, done=1, state IDLE.
- **start handling:**
  - `start` while busy is ignored; it is neither queued nor allowed to corrupt the latched request.
  - `start` in the same cycle done pulses is ignored; the earliest new accept is the cycle after done.
- **Reset:** asserting rst at any point, including mid-frame, forces IDLE, SS=1, SCLK=0, MOSI=0, busy=0, done=0, rdata=0x00 immediately (asynchronous). No partial frame resumes.

## Timing
- All outputs are registered; none are combinational from inputs.
- Let T0 be the clk edge after the edge that accepts start. The following are relative to T0, with H = SCLK_HALF:
  - SS falls and busy rises at T0.
  - Rise k (k = 1..16) of SCLK at T0 + (2k−1)·H; fall k at T0 + 2k·H.
  - SS rises, busy falls, done pulses and rdata updates at T0 + 33·H.
- Accept-to-done latency is 33·H + 1 cycles (H=4: 133).
- MOSI changes only while SCLK is low, or at SS fall. Each bit is stable ≥H cycles before and after its SCLK rise.
- SCLK is low at both SS edges.

## Configuration
- `SPI_MASTER_MISO_SYNC_EN`
  - Defined: MISO passes through a 2-flop synchroniser clocked by clk, and the capture point moves to the third cycle of HIGH (two cycles after the rise). This still lands inside the high phase because H ≥ 3.
  - Undefined: raw MISO is sampled in the first cycle of HIGH, with no added flops.
  - Frame timing, latency and all other outputs are identical in both builds.

## Test plan
- **Write:** H=4, `start` with we=1, addr=2, wdata=0xA5 → MOSI bits 0x82 then 0xA5 captured by a slave model on SCLK rises. Exactly 16 rises, SS low throughout. done pulses once at T0+132; rdata stays 0x00.
- **Read:** we=0, addr=1, slave model shifts out 0x3C as byte1 (changing on SCLK falls) → MOSI = 0x01, 0x00; rdata = 0x3C at done.
- **Busy ignore:** `start` pulsed at T0+10 and again in the done cycle → no second frame, latched addr/wdata unchanged, busy low the cycle after done. A `start` one cycle later is accepted.
- **Mid-frame reset:** rst low at rise 7 → same-cycle SS=1, SCLK=0, MOSI=0, busy=0, done never pulses. A fresh write after release completes normally.
- **Minimum divider:** H=2, read of 0xFF → done at T0+66, rdata=0xFF, every SCLK phase exactly 2 cycles.
- **Sync build:** `SPI_MASTER_MISO_SYNC_EN` defined, H=3, slave returns 0x96 → rdata = 0x96. Done cycle matches the non-sync build.
